rx_lane_dispatch_ctrl: RTL and testbench
========================================

# rx_lane_dispatch_ctrl

Receive-side controller that sits in front of the two-lane byte demux in the PHY RX path. It acquires byte alignment by detecting a run of COM characters, then steers each valid payload byte alternately to lane 0 and lane 1. Each lane has credit-based flow control against its downstream buffer, and the block back-pressures the upstream source when the targeted lane has no credit. It replaces free-running demux steering with a sequenced, flow-controlled dispatch.

## Interface
Parameters:
- COM_CHAR, 8'hBC, alignment/comma character
- SYNC_COUNT, 4, consecutive valid COM bytes required to declare sync (>=1)
- CREDITS, 4, per-lane downstream buffer depth (>=1); credit counter width CW = $clog2(CREDITS+1)

Ports:
- clk_2f  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- data_in  in  8  upstream byte
- valid_in  in  1  data_in qualifier
- ready_in  out  1  upstream may present a byte (combinational from registered state)
- credit_return_0  in  1  lane-0 downstream popped one entry (1-cycle pulse per entry)
- credit_return_1  in  1  lane-1 downstream popped one entry
- data_out_0  out  8  lane-0 byte (registered)
- valid_out_0  out  1  lane-0 strobe (registered)
- data_out_1  out  8  lane-1 byte (registered)
- valid_out_1  out  1  lane-1 strobe (registered)
- sync_ok  out  1  FSM in SYNCED
- active_lane  out  1  lane the next payload byte goes to
- drop_err  out  1  1-cycle pulse: valid byte discarded for lack of credit

## Operation
- FSM states: SEARCH, SYNCED. Reset state is SEARCH.
- SEARCH:
  - com_cnt counts consecutive valid COM_CHAR bytes.
  - A valid non-COM byte clears com_cnt.
  - Cycles with valid_in=0 leave com_cnt unchanged.
  - When a valid COM byte brings com_cnt to SYNC_COUNT, the FSM moves to SYNCED on that edge, com_cnt clears, and the lane pointer is set to 0.
  - No bytes are forwarded in SEARCH. ready_in=1.
- SYNCED:
  - A valid COM byte is consumed and not forwarded. It resets the lane pointer to 0 and does not consume credit.
  - A valid non-COM byte with ready_in=1 is dispatched to the lane at the pointer. That lane's credit decrements, and the pointer toggles.
  - ready_in = credit[pointer] != 0. COM bytes are accepted regardless of ready_in.
  - A valid non-COM byte with ready_in=0 is discarded. drop_err pulses the next cycle. The pointer and credits are unchanged. The FSM stays SYNCED.
- Credits:
  - Per-lane counter 0..CREDITS, reset value CREDITS.
  - Dispatch and credit_return on the same lane in the same cycle: net unchanged.
  - credit_return while the counter equals CREDITS is ignored (saturate; never wrap).
- No return from SYNCED to SEARCH except by reset.
- Reset values: data_out_0/1=8'h00, valid_out_0/1=0, sync_ok=0, active_lane=0, drop_err=0, ready_in=1, com_cnt=0, credits=CREDITS.

## Timing
- Dispatch latency: 1 cycle. A byte sampled at edge N appears on data_out_x with valid_out_x=1 after edge N, for exactly one cycle.
- data_out_x holds its last dispatched value while valid_out_x=0.
- At most one of valid_out_0 and valid_out_1 is high in any cycle.
- sync_ok rises after the edge that samples the SYNC_COUNT-th consecutive COM byte. A byte sampled on the next edge is the first one eligible for dispatch.
- active_lane and ready_in reflect the current registered pointer and credits. A credit_return sampled at edge N can raise ready_in after edge N.
- Asynchronous reset asserted mid-transfer clears all outputs immediately, with no pending strobe emitted. After release, operation restarts in SEARCH.

## Test plan
- Sync acquisition: after reset, drive valid BC,BC,3A,BC,BC,BC,BC with valid held. sync_ok=0 until the 7th byte's edge, then sync_ok=1; nothing is forwarded throughout.
- Valid gaps: in SEARCH, drive BC,BC, two idle cycles, BC,BC. Sync is declared on the 4th BC; the gaps do not reset the count.
- Alternating dispatch: once synced, drive 11,22,33,44. Lane 0 gets 11 then 33, lane 1 gets 22 then 44, each one cycle after sampling. A mid-stream BC before 55 sends 55 to lane 0.
- Credit exhaustion: CREDITS=4, no returns, drive 8 bytes then a 9th. ready_in=0 after the 8th byte is accepted, the 9th is dropped with a drop_err pulse, and no valid_out fires. Then pulse credit_return_0: ready_in=1 and the next byte goes to lane 0.
- Simultaneous events:
  - Dispatch to lane 1 plus credit_return_1 in the same cycle leaves credit_1 unchanged.
  - credit_return_0 at full credit stays at 4.
- Reset mid-operation: assert reset the cycle after sampling byte 5A. valid_out_x, sync_ok and active_lane are 0 immediately. After release, SEARCH is required before any further dispatch.

Source files
------------

// File: rtl/rx_lane_dispatch_ctrl.sv
// RX lane dispatch controller: acquires byte alignment on a run of COM characters,
// then steers payload bytes alternately to two credit-flow-controlled lanes.
module rx_lane_dispatch_ctrl #(
  parameter logic [7:0] COM_CHAR   = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         CREDITS    = 4
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  input  logic       credit_return_0,
  input  logic       credit_return_1,
  output logic [7:0] data_out_0,
  output logic       valid_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_1,
  output logic       sync_ok,
  output logic       active_lane,
  output logic       drop_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = $clog2(SYNC_COUNT + 1);

  // Handshake: upstream byte is taken on a rising edge when valid_in=1 and ready_in=1;
  // COM bytes are always taken, and a payload byte presented while ready_in=0 is dropped.

  typedef enum logic {SEARCH = 1'b0, SYNCED = 1'b1} state_e;

  state_e          state_q;
  logic [SW-1:0]   com_cnt_q;
  logic            lane_q;
  logic [CW-1:0]   credit0_q, credit1_q;
  logic [CW-1:0]   credit0_d, credit1_d;
  logic [7:0]      data0_q, data1_q;
  logic            valid0_q, valid1_q, drop_q;

  logic            is_com, payload, lane_ready, disp0, disp1, drop;

  // Same-cycle dispatch and return cancel; a return at full credit is ignored.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic dec, input logic ret);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (dec && !ret)
      nxt = cur - CW'(1);
    else if (ret && !dec && cur != CW'(CREDITS))
      nxt = cur + CW'(1);
    return nxt;
  endfunction

  always_comb begin
    is_com     = valid_in && (data_in == COM_CHAR);
    payload    = (state_q == SYNCED) && valid_in && (data_in != COM_CHAR);
    lane_ready = lane_q ? (credit1_q != '0) : (credit0_q != '0);
    ready_in   = (state_q == SEARCH) || lane_ready;
    disp0      = payload && lane_ready && !lane_q;
    disp1      = payload && lane_ready && lane_q;
    drop       = payload && !lane_ready;
    credit0_d  = credit_next(credit0_q, disp0, credit_return_0);
    credit1_d  = credit_next(credit1_q, disp1, credit_return_1);
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      com_cnt_q <= '0;
      lane_q    <= 1'b0;
      credit0_q <= CW'(CREDITS);
      credit1_q <= CW'(CREDITS);
      data0_q   <= 8'h00;
      data1_q   <= 8'h00;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      valid0_q  <= disp0;
      valid1_q  <= disp1;
      drop_q    <= drop;
      credit0_q <= credit0_d;
      credit1_q <= credit1_d;
      if (disp0) data0_q <= data_in;
      if (disp1) data1_q <= data_in;

      if (state_q == SEARCH) begin
        if (valid_in) begin
          if (is_com) begin
            if (com_cnt_q == SW'(SYNC_COUNT - 1)) begin
              state_q   <= SYNCED;
              com_cnt_q <= '0;
              lane_q    <= 1'b0;
            end else begin
              com_cnt_q <= com_cnt_q + SW'(1);
            end
          end else begin
            com_cnt_q <= '0;
          end
        end
      end else begin
        // A COM in the stream realigns the lane pointer without using credit.
        if (is_com)
          lane_q <= 1'b0;
        else if (disp0 || disp1)
          lane_q <= ~lane_q;
      end
    end
  end

  assign data_out_0  = data0_q;
  assign data_out_1  = data1_q;
  assign valid_out_0 = valid0_q;
  assign valid_out_1 = valid1_q;
  assign drop_err    = drop_q;
  assign sync_ok     = (state_q == SYNCED);
  assign active_lane = lane_q;

endmodule

// File: tb/tb_rx_lane_dispatch_ctrl.sv
// Directed testbench for rx_lane_dispatch_ctrl: sync acquisition, alternating
// dispatch, credit exhaustion/return, simultaneous credit events and mid-run reset.
module tb_rx_lane_dispatch_ctrl;

  logic       clk_2f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic       credit_return_0;
  logic       credit_return_1;
  logic [7:0] data_out_0;
  logic       valid_out_0;
  logic [7:0] data_out_1;
  logic       valid_out_1;
  logic       sync_ok;
  logic       active_lane;
  logic       drop_err;

  int total;
  int bad;

  rx_lane_dispatch_ctrl dut (
    .clk_2f          (clk_2f),
    .reset           (reset),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_in        (ready_in),
    .credit_return_0 (credit_return_0),
    .credit_return_1 (credit_return_1),
    .data_out_0      (data_out_0),
    .valid_out_0     (valid_out_0),
    .data_out_1      (data_out_1),
    .valid_out_1     (valid_out_1),
    .sync_ok         (sync_ok),
    .active_lane     (active_lane),
    .drop_err        (drop_err)
  );

  // clock / reset block
  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  // Present one cycle of inputs, let the edge sample them, then idle the inputs.
  task automatic drive(input logic v, input logic [7:0] d, input logic r0, input logic r1);
    valid_in        = v;
    data_in         = d;
    credit_return_0 = r0;
    credit_return_1 = r1;
    tick();
    valid_in        = 1'b0;
    credit_return_0 = 1'b0;
    credit_return_1 = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic sync_up();
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hBC, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if ({sync_ok, valid_out_0, valid_out_1, active_lane, drop_err, ready_in} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000001",
               {sync_ok, valid_out_0, valid_out_1, active_lane, drop_err, ready_in});
    end
    total++;
    if ({data_out_0, data_out_1} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0000", {data_out_0, data_out_1});
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sync_acq();
    logic [7:0] seq [7];
    seq = '{8'hBC, 8'hBC, 8'h3A, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, seq[i], 1'b0, 1'b0);
      total++;
      if (sync_ok !== (i == 6)) begin
        bad++;
        $display("FAIL sync_acq_byte%0d got=%b exp=%b", i, sync_ok, (i == 6));
      end
      total++;
      if ({valid_out_0, valid_out_1, ready_in} !== 3'b001) begin
        bad++;
        $display("FAIL sync_acq_noforward%0d got=%b exp=001", i, {valid_out_0, valid_out_1, ready_in});
      end
    end
  endtask

  task automatic test_valid_gaps();
    apply_reset();
    drive(1'b1, 8'hBC, 1'b0, 1'b0);
    drive(1'b1, 8'hBC, 1'b0, 1'b0);
    drive(1'b0, 8'h3A, 1'b0, 1'b0);
    drive(1'b0, 8'hBC, 1'b0, 1'b0);
    drive(1'b1, 8'hBC, 1'b0, 1'b0);
    total++;
    if (sync_ok !== 1'b0) begin
      bad++;
      $display("FAIL gaps_third_com got=%b exp=0", sync_ok);
    end
    drive(1'b1, 8'hBC, 1'b0, 1'b0);
    total++;
    if (sync_ok !== 1'b1) begin
      bad++;
      $display("FAIL gaps_fourth_com got=%b exp=1", sync_ok);
    end
  endtask

  task automatic test_alternating();
    logic [7:0] bytes [5];
    logic [7:0] exp0, exp1;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    sync_up();
    exp0 = 8'h00;
    exp1 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bytes[i], 1'b0, 1'b0);
      if (i % 2 == 0) exp0 = bytes[i]; else exp1 = bytes[i];
      total++;
      if ({valid_out_0, valid_out_1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL alt_strobe%0d got=%b exp=%b", i, {valid_out_0, valid_out_1},
                 ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      total++;
      if ({data_out_0, data_out_1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL alt_data%0d got=%h exp=%h", i, {data_out_0, data_out_1}, {exp0, exp1});
      end
      total++;
      if (active_lane !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL alt_lane%0d got=%b exp=%b", i, active_lane, ((i % 2 == 0) ? 1'b1 : 1'b0));
      end
    end
    // pointer now at lane 1; a mid-stream COM must pull it back to lane 0
    drive(1'b1, 8'hBC, 1'b0, 1'b0);
    total++;
    if ({valid_out_0, valid_out_1, active_lane} !== 3'b000) begin
      bad++;
      $display("FAIL alt_com got=%b exp=000", {valid_out_0, valid_out_1, active_lane});
    end
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    total++;
    if ({valid_out_0, valid_out_1, data_out_0} !== {2'b10, 8'h55}) begin
      bad++;
      $display("FAIL alt_after_com got=%b/%h exp=10/55", {valid_out_0, valid_out_1}, data_out_0);
    end
  endtask

  task automatic test_credit_exhaust();
    sync_up();
    // returns at full credit must saturate, not add a fifth credit
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      total++;
      if (ready_in !== (i != 7)) begin
        bad++;
        $display("FAIL exhaust_ready%0d got=%b exp=%b", i, ready_in, (i != 7));
      end
    end
    total++;
    if ({data_out_0, data_out_1} !== 16'h8687) begin
      bad++;
      $display("FAIL exhaust_data got=%h exp=8687", {data_out_0, data_out_1});
    end
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    total++;
    if ({drop_err, valid_out_0, valid_out_1, active_lane, sync_ok} !== 5'b10001) begin
      bad++;
      $display("FAIL exhaust_drop got=%b exp=10001",
               {drop_err, valid_out_0, valid_out_1, active_lane, sync_ok});
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if ({drop_err, ready_in} !== 2'b01) begin
      bad++;
      $display("FAIL exhaust_return got=%b exp=01", {drop_err, ready_in});
    end
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    total++;
    if ({valid_out_0, valid_out_1, data_out_0, ready_in} !== {2'b10, 8'hA5, 1'b0}) begin
      bad++;
      $display("FAIL exhaust_resume got=%b/%h/%b exp=10/a5/0",
               {valid_out_0, valid_out_1}, data_out_0, ready_in);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++;
    if (ready_in !== 1'b1) begin
      bad++;
      $display("FAIL exhaust_return1 got=%b exp=1", ready_in);
    end
  endtask

  task automatic test_simultaneous();
    sync_up();
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    // lane-1 dispatch with a lane-1 return in the same cycle: credit_1 stays 4
    drive(1'b1, 8'h20, 1'b0, 1'b1);
    total++;
    if ({valid_out_1, data_out_1} !== {1'b1, 8'h20}) begin
      bad++;
      $display("FAIL simul_dispatch got=%b/%h exp=1/20", valid_out_1, data_out_1);
    end
    // keep lane 0 topped up; lane 1 should take exactly four more bytes
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h30 + k), 1'b1, 1'b0);
      total++;
      if ({valid_out_0, ready_in} !== 2'b11) begin
        bad++;
        $display("FAIL simul_l0_%0d got=%b exp=11", k, {valid_out_0, ready_in});
      end
      drive(1'b1, 8'(8'h40 + k), 1'b1, 1'b0);
      total++;
      if (valid_out_1 !== 1'b1) begin
        bad++;
        $display("FAIL simul_l1_%0d got=%b exp=1", k, valid_out_1);
      end
    end
    drive(1'b1, 8'h50, 1'b0, 1'b0);
    total++;
    if ({valid_out_0, active_lane, ready_in} !== 3'b110) begin
      bad++;
      $display("FAIL simul_l1_empty got=%b exp=110", {valid_out_0, active_lane, ready_in});
    end
  endtask

  task automatic test_reset_mid();
    sync_up();
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    total++;
    if ({valid_out_0, data_out_0} !== {1'b1, 8'h5A}) begin
      bad++;
      $display("FAIL rstmid_pre got=%b/%h exp=1/5a", valid_out_0, data_out_0);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({valid_out_0, valid_out_1, sync_ok, active_lane, data_out_0} !== {4'b0000, 8'h00}) begin
      bad++;
      $display("FAIL rstmid_async got=%b/%h exp=0000/00",
               {valid_out_0, valid_out_1, sync_ok, active_lane}, data_out_0);
    end
    tick();
    reset = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    total++;
    if ({valid_out_0, valid_out_1, sync_ok} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_search got=%b exp=000", {valid_out_0, valid_out_1, sync_ok});
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hBC, 1'b0, 1'b0);
    drive(1'b1, 8'h78, 1'b0, 1'b0);
    total++;
    if ({sync_ok, valid_out_0, data_out_0} !== {2'b11, 8'h78}) begin
      bad++;
      $display("FAIL rstmid_resync got=%b/%h exp=11/78", {sync_ok, valid_out_0}, data_out_0);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    data_in         = 8'h00;
    valid_in        = 1'b0;
    credit_return_0 = 1'b0;
    credit_return_1 = 1'b0;
    test_reset();
    test_sync_acq();
    test_valid_gaps();
    test_alternating();
    test_credit_exhaust();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
